// File: rtl/axi_reg_bank.sv
// AXI-Lite CSR bank: commits write-stage strobes, serves AR/R channels, drives start/irq to the core.
// Writes visible next cycle; read data one cycle after AR handshake; R held until RREADY.
module axi_reg_bank #(
    parameter int NUM_REGS = 16,
    parameter int AW       = $clog2(NUM_REGS) + 3
) (
    input  logic                   axi_clk,
    input  logic                   rstn,
    input  logic                   wr_valid,
    input  logic [AW-1:0]          wr_addr,
    input  logic [31:0]            wr_data,
    input  logic [AW-1:0]          read_addr,
    input  logic                   read_addr_valid,
    output logic                   read_addr_ready,
    output logic [31:0]            read_data,
    output logic [1:0]             read_resp,
    output logic                   read_data_valid,
    input  logic                   read_data_ready,
    input  logic                   core_busy,
    input  logic                   core_done,
    output logic                   start_pulse,
    output logic                   irq,
    output logic [32*NUM_REGS-1:0] reg_out
);
    localparam int IW = AW - 3;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RESP = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic          arready_q, arready_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [1:0]    rresp_q, rresp_d;
    logic [31:1]   ctrl_q, ctrl_d;
    logic          done_q, done_d;
    logic          start_q, start_d;
    logic          irq_q, irq_d;
    logic [31:0]   gp_q [2:NUM_REGS-1];
    logic [31:0]   gp_d [2:NUM_REGS-1];

    logic [IW-1:0] wr_idx, rd_idx;
    logic          wr_hit, rd_in_range;
    logic [31:0]   img [NUM_REGS];
    logic [31:0]   rd_val;
    logic [1:0]    rd_resp;
    logic          unused_addr_lsbs;

    assign unused_addr_lsbs = ^{wr_addr[1:0], read_addr[1:0]};

    assign wr_idx      = wr_addr[AW-2:2];
    assign rd_idx      = read_addr[AW-2:2];
    assign wr_hit      = wr_valid && !wr_addr[AW-1] && (32'(wr_idx) < 32'(NUM_REGS));
    assign rd_in_range = !read_addr[AW-1] && (32'(rd_idx) < 32'(NUM_REGS));

    // Read image: START reads 0, STATUS busy is live, DONE is the sticky flop.
    always_comb begin
        reg_out = '0;
        img[0]  = {ctrl_q, 1'b0};
        img[1]  = {30'd0, done_q, core_busy};
        for (int k = 2; k < NUM_REGS; k++) begin
            img[k] = gp_q[k];
        end
        for (int k = 0; k < NUM_REGS; k++) begin
            reg_out[k*32 +: 32] = img[k];
        end
    end

    always_comb begin
        rd_val  = '0;
        rd_resp = 2'b10;
        if (rd_in_range) begin
            rd_resp = 2'b00;
            for (int k = 0; k < NUM_REGS; k++) begin
                if (32'(rd_idx) == k) begin
                    rd_val = img[k];
                end
            end
        end
    end

    always_comb begin
        ctrl_d  = ctrl_q;
        done_d  = done_q;
        start_d = 1'b0;
        gp_d    = gp_q;
        if (wr_hit) begin
            if (32'(wr_idx) == 0) begin
                ctrl_d  = wr_data[31:1];
                start_d = wr_data[0];
            end
            if (32'(wr_idx) == 1 && wr_data[1]) begin
                done_d = 1'b0;
            end
            for (int k = 2; k < NUM_REGS; k++) begin
                if (32'(wr_idx) == k) begin
                    gp_d[k] = wr_data;
                end
            end
        end
        // A completion in the same cycle as the clear must not be lost.
        if (core_done) begin
            done_d = 1'b1;
        end
        irq_d = done_q & ctrl_q[1];
    end

    always_comb begin
        state_d = state_q;
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        case (state_q)
            S_IDLE: begin
                if (read_addr_valid && arready_q) begin
                    state_d = S_RESP;
                    rdata_d = rd_val;
                    rresp_d = rd_resp;
                end
            end
            S_RESP: begin
                if (read_data_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Registered so ARREADY stays low until the first edge after reset release.
        arready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge axi_clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            arready_q <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= '0;
            ctrl_q    <= '0;
            done_q    <= 1'b0;
            start_q   <= 1'b0;
            irq_q     <= 1'b0;
            for (int k = 2; k < NUM_REGS; k++) begin
                gp_q[k] <= '0;
            end
        end else begin
            state_q   <= state_d;
            arready_q <= arready_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            ctrl_q    <= ctrl_d;
            done_q    <= done_d;
            start_q   <= start_d;
            irq_q     <= irq_d;
            gp_q      <= gp_d;
        end
    end

    assign read_addr_ready = arready_q;
    assign read_data_valid = (state_q == S_RESP);
    assign read_data       = rdata_q;
    assign read_resp       = rresp_q;
    assign start_pulse     = start_q;
    assign irq             = irq_q;

endmodule

// File: doc/axi_reg_bank.md
Name: axi_reg_bank

Overview:
- Control/status register bank that sits directly downstream of the AXI-Lite write-channel stage.
- Commits the stage's single-cycle write strobes (wr_valid/wr_addr/wr_data) into NUM_REGS 32-bit registers.
- Serves the AXI-Lite read address/data channels itself.
- Exposes all register contents, a start pulse and an interrupt to the BNN core.

Parameters:
- NUM_REGS, 16, number of 32-bit registers (>=3).
- AW, $clog2(NUM_REGS)+3, byte-address width. Equals the width produced by the write stage.

Ports:
- axi_clk  in  1  clock; all logic rising-edge.
- rstn  in  1  asynchronous active-low reset.
- wr_valid  in  1  write strobe from write stage; each high cycle commits one write.
- wr_addr  in  AW  byte address of write.
- wr_data  in  32  write data.
- read_addr  in  AW  AXI read address.
- read_addr_valid  in  1  ARVALID.
- read_addr_ready  out  1  ARREADY.
- read_data  out  32  RDATA.
- read_resp  out  2  RRESP.
- read_data_valid  out  1  RVALID.
- read_data_ready  in  1  RREADY.
- core_busy  in  1  live busy flag from core.
- core_done  in  1  one-cycle completion pulse from core.
- start_pulse  out  1  one-cycle start strobe to core.
- irq  out  1  level interrupt.
- reg_out  out  32*NUM_REGS  flat register image; slice k = read value of register k.

Behaviour:
- Index decode: idx = addr[AW-2:2]; addr[1:0] ignored.
- Access is in-range iff addr[AW-1]==0 and idx<NUM_REGS.
- Out-of-range writes are dropped. Out-of-range reads return read_data=0 with read_resp=2'b10 (SLVERR).
- Register 0, CTRL:
  - bit0 START is write-only. Writing 1 drives start_pulse high for exactly the next cycle. Reads as 0.
  - bits31:1 are plain RW storage. Bit1 is IRQ_EN.
- Register 1, STATUS:
  - bit0 reads core_busy, sampled live.
  - bit1 DONE is sticky. Set on the cycle after core_done=1. Cleared by a write with wr_data[1]=1 (W1C).
  - Other bits read 0. Writes to them are ignored.
- Registers 2..NUM_REGS-1: plain RW. Write takes effect at the clock edge where wr_valid=1. New value visible on reg_out the following cycle.
- Simultaneous core_done and DONE W1C in the same cycle: set wins, DONE=1.
- irq = DONE & IRQ_EN, registered (one cycle after either bit changes).
- Read FSM, two states:
  - IDLE: read_addr_ready=1. On read_addr_valid&read_addr_ready, capture read_data/read_resp from current register state and go to RESP.
  - RESP: read_addr_ready=0 and read_data_valid=1. read_data/read_resp are held stable until read_data_valid&read_data_ready, then return to IDLE.
  - Minimum read latency: rvalid rises 1 cycle after the address handshake.
  - Back-to-back throughput: one read per 2 cycles.
- read_resp=2'b00 for all in-range reads.
- Read and write to the same register in the same cycle: read returns the pre-write value.
- Reset, asynchronous and may occur at any time including mid-read:
  - FSM goes to IDLE.
  - All registers, DONE, start_pulse, irq, read_data_valid, read_data and read_resp go to 0.
  - read_addr_ready is 0 during reset and goes to 1 at the first clock edge after rstn deasserts.
  - An in-flight read response is abandoned.

Test Plan:
- Reset then idle: all outputs 0 during reset; read_addr_ready=1 one cycle after release; reg_out all zeros.
- Write reg 5 (byte addr 0x14) = 0xDEADBEEF, then read 0x14 -> read_data=0xDEADBEEF, read_resp=0. Hold read_data_ready=0 for 3 cycles -> read_data_valid and read_data stay stable.
- Write 0x3 to CTRL -> start_pulse high exactly 1 cycle; CTRL reads 0x2; IRQ_EN=1.
  - Pulse core_done -> STATUS bit1=1 and irq=1.
  - Write 0x2 to STATUS -> DONE=0, irq=0.
  - core_done coincident with the W1C -> DONE stays 1.
- Read addr 0x40 (addr[6]=1, NUM_REGS=16) -> read_data=0, read_resp=2'b10. Write to 0x40 -> no register changes.
- Same-cycle write 0x11111111 and read of reg 2 (previously 0xA5A5A5A5) -> read returns 0xA5A5A5A5; next read returns 0x11111111.
- Assert rstn=0 while read_data_valid=1 -> read_data_valid drops immediately (asynchronously), registers cleared; next read is served normally.
